lcd_bus_sched: RTL and testbench

- Sequences and shares the character-LCD parallel bus (8-bit DB, RS, RW, EN, RST) between two requesters: a command port and a data (character) port.
- After reset it runs a fixed power-up wait and a 4-entry init ROM.
- It then arbitrates requests round-robin and generates each EN pulse with programmable setup, high, hold and execution-wait timing.
- Sits between the display-content logic and the LCD pins; it replaces free-running counter-driven EN generation.

---
 rtl/lcd_bus_sched.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_bus_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_sched.sv
// lcd_bus_sched
//   Sequencer and arbiter for a character-LCD parallel bus. After reset it
//   waits PWRUP_WAIT cycles and replays a four-entry init ROM. It then shares
//   the bus round-robin between a command port and a data port. Each byte is
//   sent with programmable EN setup, high, hold and post-hold execution wait.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     cmd_valid/cmd_data    command request (held until cmd_ready)
//     cmd_ready             one-cycle accept strobe, command port
//     dat_valid/dat_data    character request (held until dat_ready)
//     dat_ready             one-cycle accept strobe, data port
//     init_done             set once the init ROM has been sent
//     busy                  high in every state except IDLE
//     lcd_en/rs/rw/db/rst   registered LCD pins (rw is always 0)
module lcd_bus_sched #(
   parameter int unsigned EN_SETUP   = 2,
   parameter int unsigned EN_HIGH    = 4,
   parameter int unsigned EN_HOLD    = 2,
   parameter int unsigned EXEC_WAIT  = 50,
   parameter int unsigned CLR_WAIT   = 2000,
   parameter int unsigned PWRUP_WAIT = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   input  logic       dat_valid,
   input  logic [7:0] dat_data,
   output logic       dat_ready,
   output logic       init_done,
   output logic       busy,
   output logic       lcd_en,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_db,
   output logic       lcd_rst
);

   typedef enum logic [2:0] {
      S_PWRUP,
      S_INIT_LOAD,
      S_SETUP,
      S_EN_HI,
      S_HOLD,
      S_WAIT,
      S_IDLE
   } state_t;

   // Terminal count for each timed state (counter runs 0 .. N-1).
   localparam logic [15:0] PWRUP_LAST = 16'(PWRUP_WAIT - 1);
   localparam logic [15:0] SETUP_LAST = 16'(EN_SETUP - 1);
   localparam logic [15:0] HIGH_LAST  = 16'(EN_HIGH - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(EN_HOLD - 1);
   localparam logic [15:0] EXEC_LAST  = 16'(EXEC_WAIT - 1);
   localparam logic [15:0] CLR_LAST   = 16'(CLR_WAIT - 1);

   state_t      state;
   logic [15:0] cnt;
   logic [1:0]  rom_idx;
   logic        last_dat;    // 1: the most recent grant went to the data port
   logic [7:0]  rom_byte;
   logic        grant_cmd;
   logic        grant_dat;
   logic        slow_cmd;
   logic [15:0] wait_last;

   always_comb begin
      rom_byte = 8'h38;
      case (rom_idx)
         2'd0: rom_byte = 8'h38;
         2'd1: rom_byte = 8'h0C;
         2'd2: rom_byte = 8'h01;
         2'd3: rom_byte = 8'h06;
         default: rom_byte = 8'h38;
      endcase
   end

   // Round-robin: with both ports requesting, the command port wins only if
   // the data port had the previous grant.
   always_comb begin
      grant_cmd = 1'b0;
      grant_dat = 1'b0;
      if (state == S_IDLE && init_done) begin
         if (cmd_valid && (!dat_valid || last_dat))
            grant_cmd = 1'b1;
         else if (dat_valid)
            grant_dat = 1'b1;
      end
   end

   assign cmd_ready = grant_cmd;
   assign dat_ready = grant_dat;

   // Clear and home need the long execution wait; the bus still holds the
   // byte being sent, so decode directly from the registered pins.
   assign slow_cmd  = !lcd_rs && (lcd_db == 8'h01 || lcd_db == 8'h02);
   assign wait_last = slow_cmd ? CLR_LAST : EXEC_LAST;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_PWRUP;
         cnt       <= '0;
         rom_idx   <= '0;
         last_dat  <= 1'b1;
         init_done <= 1'b0;
         busy      <= 1'b1;
         lcd_en    <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_rw    <= 1'b0;
         lcd_db    <= '0;
         lcd_rst   <= 1'b0;
      end else begin
         lcd_rst <= 1'b1;
         lcd_rw  <= 1'b0;
         case (state)
            S_PWRUP: begin
               if (cnt == PWRUP_LAST) begin
                  cnt   <= '0;
                  state <= S_INIT_LOAD;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_INIT_LOAD: begin
               lcd_db <= rom_byte;
               lcd_rs <= 1'b0;
               cnt    <= '0;
               state  <= S_SETUP;
            end
            S_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  cnt    <= '0;
                  lcd_en <= 1'b1;
                  state  <= S_EN_HI;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_EN_HI: begin
               if (cnt == HIGH_LAST) begin
                  cnt    <= '0;
                  lcd_en <= 1'b0;
                  state  <= S_HOLD;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt   <= '0;
                  state <= S_WAIT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_WAIT: begin
               if (cnt == wait_last) begin
                  cnt <= '0;
                  if (!init_done) begin
                     rom_idx <= rom_idx + 2'd1;
                     if (rom_idx == 2'd3) begin
                        init_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                     end else begin
                        state <= S_INIT_LOAD;
                     end
                  end else begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_IDLE: begin
               cnt <= '0;
               if (grant_cmd) begin
                  lcd_db   <= cmd_data;
                  lcd_rs   <= 1'b0;
                  last_dat <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_SETUP;
               end else if (grant_dat) begin
                  lcd_db   <= dat_data;
                  lcd_rs   <= 1'b1;
                  last_dat <= 1'b1;
                  busy     <= 1'b1;
                  state    <= S_SETUP;
               end
            end
            default: begin
               cnt   <= '0;
               state <= S_PWRUP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_sched.sv
// tb_lcd_bus_sched
//   Directed bench for lcd_bus_sched with default timing. A cycle-level
//   timeline model (transfer start cycle + length) predicts every output
//   on each falling clock edge; logged events are also checked against
//   hand-computed cycle numbers.
module tb_lcd_bus_sched;

   localparam int ES = 2;
   localparam int EH = 4;
   localparam int EO = 2;
   localparam int EW = 50;
   localparam int CW = 2000;
   localparam int PW = 1000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic [7:0] cmd_data;
   logic       cmd_ready;
   logic       dat_valid;
   logic [7:0] dat_data;
   logic       dat_ready;
   logic       init_done;
   logic       busy;
   logic       lcd_en;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_db;
   logic       lcd_rst;

   lcd_bus_sched #(
      .EN_SETUP(ES), .EN_HIGH(EH), .EN_HOLD(EO),
      .EXEC_WAIT(EW), .CLR_WAIT(CW), .PWRUP_WAIT(PW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .dat_valid(dat_valid), .dat_data(dat_data), .dat_ready(dat_ready),
      .init_done(init_done), .busy(busy),
      .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_db(lcd_db), .lcd_rst(lcd_rst)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- timeline model ----------------
   logic [7:0] m_rom [4];
   initial begin
      m_rom[0] = 8'h38; m_rom[1] = 8'h0C; m_rom[2] = 8'h01; m_rom[3] = 8'h06;
   end

   int         m_cyc, m_next;
   int         m_init_idx, m_next_init, m_done_at, m_busy_until;
   int         m_cur_start, m_len;
   logic [7:0] m_cur_byte;
   logic       m_cur_rs;
   logic       m_last_dat;
   logic       m_pend;
   logic [7:0] m_pend_byte;
   logic       m_pend_rs;

   // event log from observed outputs, checked against literal cycle numbers
   int         rise_c[$];
   logic [8:0] rise_v[$];
   int         fall_c[$];
   int         rdy_c[$];
   int         rdy_p[$];
   int         bfall_c[$];
   int         done_c;
   int         both_cnt;
   logic       p_en, p_busy, p_done;

   task automatic clear_log();
      rise_c.delete(); rise_v.delete(); fall_c.delete();
      rdy_c.delete(); rdy_p.delete(); bfall_c.delete();
      done_c = -1; both_cnt = 0;
   endtask

   task automatic m_reset();
      m_next = 0; m_cyc = -1;
      m_init_idx = 0; m_next_init = PW + 1;
      m_done_at = 32'h7fff_ffff; m_busy_until = 32'h7fff_ffff;
      m_cur_start = -100000; m_len = 0;
      m_cur_byte = 8'h00; m_cur_rs = 1'b0;
      m_last_dat = 1'b1; m_pend = 1'b0;
      m_pend_byte = 8'h00; m_pend_rs = 1'b0;
      p_en = 1'b0; p_busy = 1'b1; p_done = 1'b0;
   endtask

   task automatic m_start(input logic [7:0] b, input logic rs);
      int w;
      w = (!rs && (b == 8'h01 || b == 8'h02)) ? CW : EW;
      m_cur_start  = m_cyc;
      m_cur_byte   = b;
      m_cur_rs     = rs;
      m_len        = ES + EH + EO + w;
      m_busy_until = m_cyc + m_len;
   endtask

   initial m_reset();

   always @(negedge clk) begin
      logic e_idle, e_en, e_done, e_cr, e_dr;
      int d;
      if (!rst_n) begin
         m_reset();
         chk1("rst_en", lcd_en, 1'b0);
         chk1("rst_lcd_rst", lcd_rst, 1'b0);
         chk1("rst_rs", lcd_rs, 1'b0);
         chk1("rst_rw", lcd_rw, 1'b0);
         chk8("rst_db", lcd_db, 8'h00);
         chk1("rst_busy", busy, 1'b1);
         chk1("rst_init_done", init_done, 1'b0);
         chk1("rst_cmd_ready", cmd_ready, 1'b0);
         chk1("rst_dat_ready", dat_ready, 1'b0);
      end else begin
         m_cyc = m_next;
         m_next++;
         if (m_pend) begin
            m_start(m_pend_byte, m_pend_rs);
            m_pend = 1'b0;
         end else if (m_init_idx < 4 && m_cyc == m_next_init) begin
            m_start(m_rom[m_init_idx], 1'b0);
            m_next_init = m_cyc + m_len + 1;
            m_init_idx++;
            if (m_init_idx == 4) m_done_at = m_cyc + m_len;
         end
         d      = m_cyc - m_cur_start;
         e_en   = (d >= ES) && (d < ES + EH);
         e_done = (m_init_idx == 4) && (m_cyc >= m_done_at);
         e_idle = e_done && (m_cyc >= m_busy_until);
         e_cr = 1'b0;
         e_dr = 1'b0;
         if (e_idle && (cmd_valid || dat_valid)) begin
            if (cmd_valid && dat_valid) e_dr = !m_last_dat;
            else e_dr = dat_valid;
            e_cr = !e_dr;
         end
         if (e_cr) begin
            m_pend = 1'b1; m_pend_byte = cmd_data; m_pend_rs = 1'b0; m_last_dat = 1'b0;
         end
         if (e_dr) begin
            m_pend = 1'b1; m_pend_byte = dat_data; m_pend_rs = 1'b1; m_last_dat = 1'b1;
         end
         chk1("lcd_en", lcd_en, e_en);
         chk1("lcd_rst", lcd_rst, m_cyc >= 1);
         chk1("lcd_rs", lcd_rs, m_cur_rs);
         chk1("lcd_rw", lcd_rw, 1'b0);
         chk8("lcd_db", lcd_db, m_cur_byte);
         chk1("busy", busy, !e_idle);
         chk1("init_done", init_done, e_done);
         chk1("cmd_ready", cmd_ready, e_cr);
         chk1("dat_ready", dat_ready, e_dr);

         if (lcd_en === 1'b1 && !p_en) begin
            rise_c.push_back(m_cyc);
            rise_v.push_back({lcd_rs, lcd_db});
         end
         if (lcd_en === 1'b0 && p_en) fall_c.push_back(m_cyc);
         if (busy === 1'b0 && p_busy) bfall_c.push_back(m_cyc);
         if (init_done === 1'b1 && !p_done) done_c = m_cyc;
         if (cmd_ready === 1'b1) begin rdy_c.push_back(m_cyc); rdy_p.push_back(0); end
         if (dat_ready === 1'b1) begin rdy_c.push_back(m_cyc); rdy_p.push_back(1); end
         if (cmd_ready === 1'b1 && dat_ready === 1'b1) both_cnt++;
         p_en = lcd_en; p_busy = busy; p_done = init_done;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_init(input int limit);
      int n = 0;
      while (init_done !== 1'b1 && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      chk1("init_done_within_bound", init_done, 1'b1);
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(negedge clk); #1;
         n++;
      end
      chk1("idle_within_bound", busy, 1'b0);
   endtask

   // holds the request until the strobe is seen, returns the accept cycle
   task automatic send(input bit is_dat, input logic [7:0] b, input int limit,
                       output int acc);
      int n = 0;
      bit got = 0;
      acc = -1;
      @(posedge clk); #1;
      if (is_dat) begin dat_valid = 1'b1; dat_data = b; end
      else begin cmd_valid = 1'b1; cmd_data = b; end
      while (!got && n < limit) begin
         @(negedge clk); #1;
         n++;
         if ((is_dat ? dat_ready : cmd_ready) === 1'b1) begin
            got = 1; acc = m_cyc;
         end
      end
      chki("accept_within_bound", int'(got), 1);
      @(posedge clk); #1;
      if (is_dat) dat_valid = 1'b0; else cmd_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      int acc, acc2, n;
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_data = 8'h00;
      dat_valid = 1'b0; dat_data = 8'h00;
      clear_log();

      // 1: power-up and init with no requests
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      wait_init(4000);
      idle_cycles(5);
      chki("init_pulse_count", rise_c.size(), 4);
      if (rise_c.size() == 4 && fall_c.size() >= 4) begin
         chki("init_byte0", int'(rise_v[0]), 9'h038);
         chki("init_byte1", int'(rise_v[1]), 9'h00C);
         chki("init_byte2", int'(rise_v[2]), 9'h001);
         chki("init_byte3", int'(rise_v[3]), 9'h006);
         chki("first_en_rise", rise_c[0], 1003);
         // low time = hold + wait + load cycle + setup
         chki("gap_after_0x38", rise_c[1] - fall_c[0], 55);
         chki("gap_after_0x01", rise_c[3] - fall_c[2], 2005);
         chki("en_width", fall_c[3] - rise_c[3], 4);
      end
      chki("init_done_cycle", done_c, 3186);
      chki("busy_fall_at_init_done", bfall_c.size() > 0 ? bfall_c[bfall_c.size()-1] : -1, 3186);

      // 2: single character
      clear_log();
      send(1'b1, 8'h41, 50, acc);
      idle_cycles(70);
      chki("s2_ready_count", rdy_c.size(), 1);
      chki("s2_en_rise_offset", rise_c.size() > 0 ? rise_c[0] - acc : -1, 3);
      chki("s2_en_fall_offset", fall_c.size() > 0 ? fall_c[0] - acc : -1, 7);
      chki("s2_busy_fall_offset", bfall_c.size() > 0 ? bfall_c[0] - acc : -1, 59);
      chki("s2_en_value", rise_v.size() > 0 ? int'(rise_v[0]) : -1, 9'h141);

      // 3: both ports requesting continuously
      clear_log();
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_data = 8'h80;
      dat_valid = 1'b1; dat_data = 8'h42;
      n = 0;
      while (rdy_c.size() < 4 && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0; dat_valid = 1'b0;
      wait_idle(100);
      chki("s3_ready_count", rdy_c.size(), 4);
      chki("s3_both_strobes", both_cnt, 0);
      if (rdy_c.size() == 4) begin
         chki("s3_grant0", rdy_p[0], 0);
         chki("s3_grant1", rdy_p[1], 1);
         chki("s3_grant2", rdy_p[2], 0);
         chki("s3_grant3", rdy_p[3], 1);
         chki("s3_spacing01", rdy_c[1] - rdy_c[0], 59);
         chki("s3_spacing12", rdy_c[2] - rdy_c[1], 59);
         chki("s3_spacing23", rdy_c[3] - rdy_c[2], 59);
      end

      // 4: clear command, then a normal command
      clear_log();
      send(1'b0, 8'h01, 50, acc);
      wait_idle(2100);
      chki("s4_clr_busy_len", bfall_c.size() > 0 ? bfall_c[0] - acc : -1, 2009);
      send(1'b0, 8'h14, 50, acc2);
      wait_idle(100);
      chki("s4_norm_busy_len", bfall_c.size() > 1 ? bfall_c[1] - acc2 : -1, 59);

      // 5: data request pending across reset and init
      @(posedge clk); #2 rst_n = 1'b0;
      dat_valid = 1'b1; dat_data = 8'h55;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      clear_log();
      n = 0;
      while (dat_ready !== 1'b1 && n < 4000) begin
         @(negedge clk); #1;
         n++;
      end
      chk1("s5_accepted", dat_ready, 1'b1);
      chki("s5_accept_cycle", m_cyc, 3186);
      chki("s5_done_cycle", done_c, 3186);
      @(posedge clk); #1;
      dat_valid = 1'b0;

      // 6: reset during EN high
      n = 0;
      while (lcd_en !== 1'b1 && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      chk1("s6_en_seen", lcd_en, 1'b1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk1("s6_en_async_drop", lcd_en, 1'b0);
      chk1("s6_rst_async_drop", lcd_rst, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      clear_log();
      wait_init(4000);
      idle_cycles(200);
      chki("s6_rerun_pulses", rise_c.size(), 4);
      chki("s6_no_replay_ready", rdy_c.size(), 0);
      chki("s6_rerun_done_cycle", done_c, 3186);
      chk8("s6_last_db", lcd_db, 8'h06);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
